mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage of the MIPS core, directly downstream of the EX/MEM register.
- Holds the byte-addressable data memory, little-endian.
- Performs stores with byte, half or word width, and formats loads with sign or zero extension.
- Registers the results into the MEM/WB pipeline register that feeds write-back.

Parameters:
- BUS_SIZE, 32, datapath width.
- MEM_ADDR_SIZE, 5, word-index width of the data memory; depth is 2^MEM_ADDR_SIZE words.
- REG_ADDR_SIZE, 5, register-file destination index width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  pipeline advance; low means stall.
- i_flush  in  1  synchronous clear of the MEM/WB register.
- i_mem_rd_src  in  3  load format.
- i_mem_wr_src  in  2  store width.
- i_mem_write  in  1  store strobe.
- i_wb  in  1  register write-back enable.
- i_mem_to_reg  in  1  write-back source select: 1 = memory, 0 = ALU.
- i_bus_b  in  BUS_SIZE  store data.
- i_alu_result  in  BUS_SIZE  byte address, or ALU result to pass through.
- i_addr_wr  in  REG_ADDR_SIZE  destination register index.
- o_wb  out  1  registered.
- o_mem_to_reg  out  1  registered.
- o_mem_rd_data  out  BUS_SIZE  registered formatted load data.
- o_alu_result  out  BUS_SIZE  registered.
- o_addr_wr  out  REG_ADDR_SIZE  registered.

Behaviour:
- Address decode:
  - word index = i_alu_result[MEM_ADDR_SIZE+1:2].
  - byte offset = [1:0].
  - Upper address bits are ignored, so out-of-range addresses wrap.
- Halfword accesses use bit [1] only; bit [0] is ignored and the access aligns down.
- Word accesses ignore [1:0].
- No misalignment trap.
- Store, on posedge i_clk when i_mem_write && i_enable && !i_reset:
  - wr_src 00 (SB): write byte lane [offset] with i_bus_b[7:0].
  - wr_src 01 (SH): write half lane [bit1] with i_bus_b[15:0].
  - wr_src 10/11 (SW): write the full word.
  - Other lanes are preserved.
- i_flush does not block a store in the same cycle.
- Load read is combinational from the array, then formatted:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 010 LW: full word.
  - 011 LBU: zero-extend the selected byte.
  - 100 LHU: zero-extend the selected half.
  - 101–111: treated as LW.
- Load data is computed every cycle regardless of i_mem_to_reg.
- MEM/WB register:
  - On posedge with i_enable, captures wb, mem_to_reg, formatted load, i_alu_result and i_addr_wr.
  - Latency is 1 cycle.
  - With i_enable low, the register holds its contents and no store occurs.
- i_flush (sampled at posedge) clears all MEM/WB outputs to 0 and takes priority over i_enable. The store still completes as above.
- Reset (asynchronous):
  - All outputs go to 0.
  - All memory words go to 0.
  - A store in progress at a reset edge is discarded.
- Read-after-write: a store at edge N is visible to a load presented in cycle N+1; there is no write-to-read bypass within the same cycle.
- Only one access per cycle occurs, because load and store are mutually exclusive per instruction. If both are asserted, the store executes and the load data reflects pre-store contents.

Optional Feature:
- Macro: MEM_STAGE_DEBUG_PORT_EN.
- When defined, adds two ports:
  - i_dbg_addr  in  MEM_ADDR_SIZE  word index.
  - o_dbg_data  out  BUS_SIZE  combinational raw word at i_dbg_addr.
- The debug port is used by the debug unit to dump data memory while the pipeline is halted.
- The debug port is independent of i_enable and reads 0 after reset.
- When the macro is undefined, both ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then LW at address 0x0C -> o_mem_rd_data=0 one cycle later; all outputs 0 during and after reset.
- SW 0x8081_F2A3 at 0x10, then in following cycles:
  - LB 0x10 -> 0xFFFF_FFA3.
  - LBU 0x11 -> 0x0000_00F2.
  - LH 0x12 -> 0xFFFF_8081.
  - LHU 0x10 -> 0x0000_F2A3.
  - LW 0x10 -> 0x8081_F2A3.
- SW 0x1122_3344 at 0x20, SB 0xAB at 0x21, SH 0xCDEF at 0x22, then LW 0x20 -> 0xCDEF_AB44.
- Stall: i_enable=0 with i_mem_write=1 -> memory unchanged and MEM/WB outputs held. Flush with wb=1 -> o_wb=0 and o_addr_wr=0 next cycle.
- Wrap: with MEM_ADDR_SIZE=5, SW 0xDEAD_BEEF at 0x80 -> LW 0x00 returns 0xDEAD_BEEF. Pass-through: mem_to_reg=0, alu_result=0x1234, addr_wr=7 -> same values on outputs one cycle later.
- MEM_STAGE_DEBUG_PORT_EN: after SW 0xCAFE_0001 at 0x08, set i_dbg_addr=2 with i_enable=0 -> o_dbg_data=0xCAFE_0001 combinationally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: little-endian byte-addressable data memory plus the MEM/WB register.
// Optional debug read port enabled by defining MEM_STAGE_DEBUG_PORT_EN.
module mem_stage #(
    parameter int BUS_SIZE      = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
`ifdef MEM_STAGE_DEBUG_PORT_EN
    input  logic [MEM_ADDR_SIZE-1:0] i_dbg_addr,
    output logic [BUS_SIZE-1:0]      o_dbg_data,
`endif
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic [2:0]               i_mem_rd_src,
    input  logic [1:0]               i_mem_wr_src,
    input  logic                     i_mem_write,
    input  logic                     i_wb,
    input  logic                     i_mem_to_reg,
    input  logic [BUS_SIZE-1:0]      i_bus_b,
    input  logic [BUS_SIZE-1:0]      i_alu_result,
    input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
    output logic                     o_wb,
    output logic                     o_mem_to_reg,
    output logic [BUS_SIZE-1:0]      o_mem_rd_data,
    output logic [BUS_SIZE-1:0]      o_alu_result,
    output logic [REG_ADDR_SIZE-1:0] o_addr_wr
);

    localparam int DEPTH = 1 << MEM_ADDR_SIZE;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b011,
        LD_LHU = 3'b100
    } ld_fmt_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01
    } st_fmt_e;

    logic [MEM_ADDR_SIZE-1:0] wordIdx;
    logic [1:0]               byteOff;
    logic [BUS_SIZE-1:0]      mem_q [DEPTH];
    logic [BUS_SIZE-1:0]      rdWord;
    logic [BUS_SIZE-1:0]      wrWord_d;
    logic [BUS_SIZE-1:0]      ldData_d;
    logic [7:0]               ldByte;
    logic [15:0]              ldHalf;

    logic                     wb_q;
    logic                     memToReg_q;
    logic [BUS_SIZE-1:0]      rdData_q;
    logic [BUS_SIZE-1:0]      aluResult_q;
    logic [REG_ADDR_SIZE-1:0] addrWr_q;

    // Upper address bits are dropped so out-of-range addresses wrap around the array.
    assign wordIdx = i_alu_result[MEM_ADDR_SIZE+1:2];
    assign byteOff = i_alu_result[1:0];

    assign rdWord = mem_q[wordIdx];
    assign ldByte = rdWord[{byteOff, 3'b000} +: 8];
    assign ldHalf = rdWord[{byteOff[1], 4'b0000} +: 16];

    // Stores are read-modify-write of the addressed word so untouched lanes keep their bytes.
    always_comb begin
        wrWord_d = rdWord;
        case (i_mem_wr_src)
            ST_SB:   wrWord_d[{byteOff, 3'b000} +: 8] = i_bus_b[7:0];
            ST_SH:   wrWord_d[{byteOff[1], 4'b0000} +: 16] = i_bus_b[15:0];
            default: wrWord_d = i_bus_b;
        endcase
    end

    always_comb begin
        ldData_d = rdWord;
        case (i_mem_rd_src)
            LD_LB:   ldData_d = {{(BUS_SIZE-8){ldByte[7]}}, ldByte};
            LD_LH:   ldData_d = {{(BUS_SIZE-16){ldHalf[15]}}, ldHalf};
            LD_LBU:  ldData_d = {{(BUS_SIZE-8){1'b0}}, ldByte};
            LD_LHU:  ldData_d = {{(BUS_SIZE-16){1'b0}}, ldHalf};
            default: ldData_d = rdWord;
        endcase
    end

    // Flush only clears the pipeline register; it deliberately does not gate the store.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_mem_write && i_enable) begin
            mem_q[wordIdx] <= wrWord_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_q        <= 1'b0;
            memToReg_q  <= 1'b0;
            rdData_q    <= '0;
            aluResult_q <= '0;
            addrWr_q    <= '0;
        end else if (i_flush) begin
            wb_q        <= 1'b0;
            memToReg_q  <= 1'b0;
            rdData_q    <= '0;
            aluResult_q <= '0;
            addrWr_q    <= '0;
        end else if (i_enable) begin
            wb_q        <= i_wb;
            memToReg_q  <= i_mem_to_reg;
            rdData_q    <= ldData_d;
            aluResult_q <= i_alu_result;
            addrWr_q    <= i_addr_wr;
        end
    end

    assign o_wb          = wb_q;
    assign o_mem_to_reg  = memToReg_q;
    assign o_mem_rd_data = rdData_q;
    assign o_alu_result  = aluResult_q;
    assign o_addr_wr     = addrWr_q;

`ifdef MEM_STAGE_DEBUG_PORT_EN
    assign o_dbg_data = mem_q[i_dbg_addr];
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, reset/stall/flush sequences, then random
// traffic checked against a byte-array reference model.
module tb_mem_stage;

    localparam int BUS_SIZE      = 32;
    localparam int MEM_ADDR_SIZE = 5;
    localparam int REG_ADDR_SIZE = 5;
    localparam int MEM_BYTES     = 4 << MEM_ADDR_SIZE;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fl;
    logic [2:0]  rdSrc;
    logic [1:0]  wrSrc;
    logic        memWrite;
    logic        wbIn;
    logic        m2rIn;
    logic [31:0] busB;
    logic [31:0] aluIn;
    logic [4:0]  awrIn;
    logic        wbOut;
    logic        m2rOut;
    logic [31:0] rdOut;
    logic [31:0] aluOut;
    logic [4:0]  awrOut;
`ifdef MEM_STAGE_DEBUG_PORT_EN
    logic [4:0]  dbgAddr;
    logic [31:0] dbgData;
`endif

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        en;
        logic        fl;
        logic [2:0]  rd;
        logic [1:0]  ws;
        logic        mw;
        logic        wb;
        logic        m2r;
        logic [31:0] busB;
        logic [31:0] alu;
        logic [4:0]  awr;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        eWb;
        logic        eM2r;
        logic [31:0] eRd;
        logic [31:0] eAlu;
        logic [4:0]  eAwr;
    } vec_t;

    // Reference model: plain byte array plus the expected MEM/WB contents.
    logic [7:0]  mMem [MEM_BYTES];
    logic        mWb;
    logic        mM2r;
    logic [31:0] mRd;
    logic [31:0] mAlu;
    logic [4:0]  mAwr;

    mem_stage #(
        .BUS_SIZE(BUS_SIZE),
        .MEM_ADDR_SIZE(MEM_ADDR_SIZE),
        .REG_ADDR_SIZE(REG_ADDR_SIZE)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
`ifdef MEM_STAGE_DEBUG_PORT_EN
        .i_dbg_addr(dbgAddr),
        .o_dbg_data(dbgData),
`endif
        .i_enable(en),
        .i_flush(fl),
        .i_mem_rd_src(rdSrc),
        .i_mem_wr_src(wrSrc),
        .i_mem_write(memWrite),
        .i_wb(wbIn),
        .i_mem_to_reg(m2rIn),
        .i_bus_b(busB),
        .i_alu_result(aluIn),
        .i_addr_wr(awrIn),
        .o_wb(wbOut),
        .o_mem_to_reg(m2rOut),
        .o_mem_rd_data(rdOut),
        .o_alu_result(aluOut),
        .o_addr_wr(awrOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mkStim(logic e, logic f, logic [2:0] r, logic [1:0] w, logic m,
                                     logic wb, logic m2r, logic [31:0] b, logic [31:0] a,
                                     logic [4:0] d);
        stim_t s;
        s.en = e; s.fl = f; s.rd = r; s.ws = w; s.mw = m;
        s.wb = wb; s.m2r = m2r; s.busB = b; s.alu = a; s.awr = d;
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t s, logic ewb, logic em2r, logic [31:0] erd,
                                   logic [31:0] ealu, logic [4:0] eawr);
        vec_t v;
        v.s = s; v.eWb = ewb; v.eM2r = em2r; v.eRd = erd; v.eAlu = ealu; v.eAwr = eawr;
        return v;
    endfunction

    function automatic logic [31:0] modelLoad(logic [2:0] fmt, logic [31:0] addr);
        int a;
        int wBase;
        int hBase;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        a     = int'(addr & (MEM_BYTES - 1));
        wBase = a & ~3;
        hBase = a & ~1;
        b = mMem[a];
        h = {mMem[hBase + 1], mMem[hBase]};
        w = {mMem[wBase + 3], mMem[wBase + 2], mMem[wBase + 1], mMem[wBase]};
        case (fmt)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd3:    return {24'd0, b};
            3'd4:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic modelStore(logic [1:0] width, logic [31:0] addr, logic [31:0] data);
        int a;
        a = int'(addr & (MEM_BYTES - 1));
        if (width == 2'd0) begin
            mMem[a] = data[7:0];
        end else if (width == 2'd1) begin
            mMem[a & ~1]       = data[7:0];
            mMem[(a & ~1) + 1] = data[15:8];
        end else begin
            for (int k = 0; k < 4; k++) mMem[(a & ~3) + k] = data[8*k +: 8];
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < MEM_BYTES; k++) mMem[k] = 8'h00;
        mWb = 1'b0; mM2r = 1'b0; mRd = '0; mAlu = '0; mAwr = '0;
    endtask

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string tag, logic eWb, logic eM2r, logic [31:0] eRd,
                               logic [31:0] eAlu, logic [4:0] eAwr);
        vectors++;
        checkVal({tag, ".wb"},      {31'd0, wbOut},  {31'd0, eWb});
        checkVal({tag, ".m2r"},     {31'd0, m2rOut}, {31'd0, eM2r});
        checkVal({tag, ".rdData"},  rdOut,           eRd);
        checkVal({tag, ".alu"},     aluOut,          eAlu);
        checkVal({tag, ".addrWr"},  {27'd0, awrOut}, {27'd0, eAwr});
    endtask

    // Drive one cycle of inputs, advance the model, and land #1 after the clock edge.
    task automatic applyStimulus(stim_t s);
        logic [31:0] ld;
        en = s.en; fl = s.fl; rdSrc = s.rd; wrSrc = s.ws; memWrite = s.mw;
        wbIn = s.wb; m2rIn = s.m2r; busB = s.busB; aluIn = s.alu; awrIn = s.awr;
        ld = modelLoad(s.rd, s.alu);
        if (s.fl) begin
            mWb = 1'b0; mM2r = 1'b0; mRd = '0; mAlu = '0; mAwr = '0;
        end else if (s.en) begin
            mWb = s.wb; mM2r = s.m2r; mRd = ld; mAlu = s.alu; mAwr = s.awr;
        end
        if (s.mw && s.en) modelStore(s.ws, s.alu, s.busB);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [$];
    stim_t rs;

    initial begin
        rst = 1'b1; en = 1'b0; fl = 1'b0; rdSrc = 3'd0; wrSrc = 2'd0; memWrite = 1'b0;
        wbIn = 1'b0; m2rIn = 1'b0; busB = '0; aluIn = '0; awrIn = '0;
`ifdef MEM_STAGE_DEBUG_PORT_EN
        dbgAddr = 5'd0;
`endif
        modelReset();

        #2;
        checkOutput("rstAsync", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        checkOutput("rstHeld", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("postRst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        //                    en fl rd    ws    mw wb m2r busB          alu           awr     eWb eM2r eRd          eAlu          eAwr
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h0000000C, 5'd3), 1, 1, 32'h00000000, 32'h0000000C, 5'd3));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd2, 1, 0, 0, 32'h8081F2A3, 32'h00000010, 5'd0), 0, 0, 32'h00000000, 32'h00000010, 5'd0));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd0, 2'd0, 0, 1, 1, 32'h0,        32'h00000010, 5'd4), 1, 1, 32'hFFFFFFA3, 32'h00000010, 5'd4));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd3, 2'd0, 0, 1, 1, 32'h0,        32'h00000011, 5'd5), 1, 1, 32'h000000F2, 32'h00000011, 5'd5));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd1, 2'd0, 0, 1, 1, 32'h0,        32'h00000012, 5'd6), 1, 1, 32'hFFFF8081, 32'h00000012, 5'd6));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd4, 2'd0, 0, 1, 1, 32'h0,        32'h00000010, 5'd7), 1, 1, 32'h0000F2A3, 32'h00000010, 5'd7));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h00000010, 5'd8), 1, 1, 32'h8081F2A3, 32'h00000010, 5'd8));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd2, 1, 0, 0, 32'h11223344, 32'h00000020, 5'd0), 0, 0, 32'h00000000, 32'h00000020, 5'd0));
        // Load and store together: load data must show the word before the store lands.
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 1, 0, 0, 32'hFFFFFFAB, 32'h00000021, 5'd0), 0, 0, 32'h11223344, 32'h00000021, 5'd0));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd1, 1, 0, 0, 32'h9999CDEF, 32'h00000023, 5'd0), 0, 0, 32'h1122AB44, 32'h00000023, 5'd0));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h00000020, 5'd9), 1, 1, 32'hCDEFAB44, 32'h00000020, 5'd9));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd2, 1, 0, 0, 32'hDEADBEEF, 32'h00000080, 5'd0), 0, 0, 32'h00000000, 32'h00000080, 5'd0));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h00000000, 5'd1), 1, 1, 32'hDEADBEEF, 32'h00000000, 5'd1));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 0, 32'h0,        32'h00001234, 5'd7), 1, 0, 32'h00000000, 32'h00001234, 5'd7));
        tbl.push_back(mkVec(mkStim(0, 0, 3'd2, 2'd2, 1, 0, 1, 32'h55555555, 32'h00000010, 5'd9), 1, 0, 32'h00000000, 32'h00001234, 5'd7));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h00000010, 5'd2), 1, 1, 32'h8081F2A3, 32'h00000010, 5'd2));
        tbl.push_back(mkVec(mkStim(1, 1, 3'd2, 2'd2, 1, 1, 1, 32'h00000077, 32'h00000044, 5'd5), 0, 0, 32'h00000000, 32'h00000000, 5'd0));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h00000044, 5'd5), 1, 1, 32'h00000077, 32'h00000044, 5'd5));
        tbl.push_back(mkVec(mkStim(0, 1, 3'd2, 2'd2, 1, 1, 1, 32'h00000066, 32'h00000048, 5'd6), 0, 0, 32'h00000000, 32'h00000000, 5'd0));
        tbl.push_back(mkVec(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0,        32'h00000048, 5'd6), 1, 1, 32'h00000000, 32'h00000048, 5'd6));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("vec%0d", i), tbl[i].eWb, tbl[i].eM2r, tbl[i].eRd,
                        tbl[i].eAlu, tbl[i].eAwr);
        end

        // Reset asserted while a store is pending: the store must be discarded and memory cleared.
        en = 1'b1; fl = 1'b0; memWrite = 1'b1; wrSrc = 2'd2; busB = 32'h5A5A5A5A;
        aluIn = 32'h00000050; wbIn = 1'b1; m2rIn = 1'b1; awrIn = 5'd3; rdSrc = 3'd2;
        rst = 1'b1;
        #1;
        checkOutput("midRst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0, 32'h00000050, 5'd3));
        checkOutput("rstDropStore", 1'b1, 1'b1, 32'h00000000, 32'h00000050, 5'd3);
        applyStimulus(mkStim(1, 0, 3'd2, 2'd0, 0, 1, 1, 32'h0, 32'h00000010, 5'd4));
        checkOutput("rstClearMem", 1'b1, 1'b1, 32'h00000000, 32'h00000010, 5'd4);

`ifdef MEM_STAGE_DEBUG_PORT_EN
        dbgAddr = 5'd4;
        #1;
        vectors++;
        checkVal("dbgAfterRst", dbgData, 32'h0);
        applyStimulus(mkStim(1, 0, 3'd2, 2'd2, 1, 0, 0, 32'hCAFE0001, 32'h00000008, 5'd0));
        en = 1'b0; memWrite = 1'b0;
        dbgAddr = 5'd2;
        #1;
        vectors++;
        checkVal("dbgRead", dbgData, 32'hCAFE0001);
`endif

        // Random traffic; addresses are full 32-bit so wrap-around is exercised too.
        for (int n = 0; n < 400; n++) begin
            rs.en   = ($urandom_range(0, 7) != 0);
            rs.fl   = ($urandom_range(0, 15) == 0);
            rs.rd   = 3'($urandom_range(0, 7));
            rs.ws   = 2'($urandom_range(0, 3));
            rs.mw   = 1'($urandom_range(0, 1));
            rs.wb   = 1'($urandom_range(0, 1));
            rs.m2r  = 1'($urandom_range(0, 1));
            rs.busB = $urandom;
            rs.alu  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
            rs.awr  = 5'($urandom_range(0, 31));
            applyStimulus(rs);
            checkOutput($sformatf("rnd%0d", n), mWb, mM2r, mRd, mAlu, mAwr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
